// File: rtl/iobuf_hdx_ctrl.sv
// Half-duplex tristate pad controller: sequences bus turnaround, write drive and
// read sample windows for a WIDTH-bit IOBUF bank.
module iobuf_hdx_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TURN_CYC   = 2,
    parameter int unsigned DRIVE_CYC  = 4,
    parameter int unsigned SAMPLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             hiz,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    output logic             busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LD  = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        DRIVE  = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q;
    logic               last_dir_q;
    logic [WIDTH-1:0]   data_q;
    logic               rst_meta_q, rst_sync_q;
    logic               accept_c;
    logic               capture_c;
    logic               drive_load_c;
    logic [WIDTH-1:0]   drive_data_c;

    // Reset asserts asynchronously; release is delayed two edges before commands are taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign accept_c  = cmd_valid & cmd_ready & rst_sync_q;
    assign pad_t     = {WIDTH{hiz | (state_q != DRIVE)}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: every entry loads the window length minus one, exit on zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_c    = 1'b0;
        drive_load_c = 1'b0;
        drive_data_c = data_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (cmd_wr != last_dir_q) begin
                        state_d = TURN;
                        cnt_d   = TURN_LD;
                    end else if (cmd_wr) begin
                        state_d      = DRIVE;
                        cnt_d        = DRIVE_LD;
                        drive_load_c = 1'b1;
                        drive_data_c = cmd_data;
                    end else begin
                        state_d = SAMPLE;
                        cnt_d   = SAMPLE_LD;
                    end
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    if (dir_q) begin
                        state_d      = DRIVE;
                        cnt_d        = DRIVE_LD;
                        drive_load_c = 1'b1;
                    end else begin
                        state_d = SAMPLE;
                        cnt_d   = SAMPLE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    capture_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture, pad drive data and read response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= 1'b0;
            last_dir_q <= 1'b0;
            data_q     <= '0;
            pad_o      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            if (accept_c) begin
                dir_q      <= cmd_wr;
                last_dir_q <= cmd_wr;
                data_q     <= cmd_data;
            end
            if (drive_load_c) begin
                pad_o <= drive_data_c;
            end
            rsp_valid <= capture_c;
            if (capture_c) begin
                rsp_data <= pad_i;
            end
        end
    end

endmodule

// File: tb/tb_iobuf_hdx_ctrl.sv
// Self-checking bench for iobuf_hdx_ctrl: directed command table, reset corner
// sequences and randomized commands against a transaction-level model.
module tb_iobuf_hdx_ctrl;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned TURN_CYC   = 2;
    localparam int unsigned DRIVE_CYC  = 4;
    localparam int unsigned SAMPLE_CYC = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_wr;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             hiz;
    logic [WIDTH-1:0] pad_i, pad_o, pad_t;
    logic             busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: only the externally visible history matters.
    bit               m_last_dir;
    logic [WIDTH-1:0] m_pad_o;
    logic [WIDTH-1:0] m_rsp;

    typedef struct {
        bit               wr;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] pin;
        int               gap;
        int               hlo;
        int               hhi;
        bit               exp_turn;
        int               exp_len;
    } vec_t;

    iobuf_hdx_ctrl #(
        .WIDTH(WIDTH), .TURN_CYC(TURN_CYC), .DRIVE_CYC(DRIVE_CYC), .SAMPLE_CYC(SAMPLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .hiz(hiz), .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            hiz       = 1'b0;
            pad_i     = WIDTH'($urandom);
            #1;
            chk("idle_ready", 32'(cmd_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pad_t", 32'(pad_t), 32'hFF);
            chk("idle_pad_o", 32'(pad_o), 32'(m_pad_o));
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_rsp_data", 32'(rsp_data), 32'(m_rsp));
        end
    endtask

    // Called settled in an IDLE cycle (cycle 0); returns settled in cycle exp_len+1.
    task automatic run_cmd(input bit wr, input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] pin,
                           input int hlo, input int hhi, input bit exp_turn, input int exp_len);
        int tl;
        logic [WIDTH-1:0] exp_t;
        tl = exp_turn ? int'(TURN_CYC) : 0;
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_data  = data;
        for (int k = 1; k <= exp_len + 1; k++) begin
            @(negedge clk);
            cmd_valid = (k <= exp_len) ? 1'($urandom) : 1'b0;
            cmd_wr    = 1'($urandom);
            cmd_data  = WIDTH'($urandom);
            pad_i     = (k == exp_len) ? pin : ~pin;
            hiz       = (k >= hlo) && (k <= hhi);
            #1;
            if (k <= exp_len) begin
                exp_t = (hiz || k <= tl || !wr) ? 8'hFF : 8'h00;
                chk($sformatf("busy@%0d", k), 32'(busy), 32'd1);
                chk($sformatf("ready@%0d", k), 32'(cmd_ready), 32'd0);
                chk($sformatf("pad_t@%0d", k), 32'(pad_t), 32'(exp_t));
                chk($sformatf("rsp_valid@%0d", k), 32'(rsp_valid), 32'd0);
                if (wr && k > tl) chk($sformatf("pad_o@%0d", k), 32'(pad_o), 32'(data));
            end else begin
                chk("done_ready", 32'(cmd_ready), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_pad_t", 32'(pad_t), 32'hFF);
                chk("done_pad_o", 32'(pad_o), wr ? 32'(data) : 32'(m_pad_o));
                chk("done_rsp_valid", 32'(rsp_valid), wr ? 32'd0 : 32'd1);
                chk("done_rsp_data", 32'(rsp_data), wr ? 32'(m_rsp) : 32'(pin));
            end
        end
        m_last_dir = wr;
        if (wr) m_pad_o = data;
        else    m_rsp   = pin;
    endtask

    task automatic model_reset();
        m_last_dir = 1'b0;
        m_pad_o    = '0;
        m_rsp      = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pad_t"}, 32'(pad_t), 32'hFF);
        chk({tag, "_pad_o"}, 32'(pad_o), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_data = '0; hiz = 1'b0; pad_i = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_async");
        @(negedge clk); @(negedge clk);
        #1 check_reset_vals("rst_hold");
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        @(negedge clk);
        #1 chk("sync_first_edge_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b0;
        idle(3);

        //          wr   data   pin    gap hlo hhi turn len
        vecs[0] = '{1'b1, 8'hA5, 8'h00, 0, 0, -1, 1'b1, 6};
        vecs[1] = '{1'b1, 8'h3C, 8'h00, 0, 0, -1, 1'b0, 4};
        vecs[2] = '{1'b1, 8'h81, 8'h00, 0, 0, -1, 1'b0, 4};
        vecs[3] = '{1'b0, 8'h00, 8'h5A, 0, 0, -1, 1'b1, 5};
        vecs[4] = '{1'b0, 8'h00, 8'h11, 0, 0, -1, 1'b0, 3};
        vecs[5] = '{1'b0, 8'h00, 8'h22, 0, 0, -1, 1'b0, 3};
        vecs[6] = '{1'b1, 8'h5C, 8'h00, 2, 0, -1, 1'b1, 6};
        vecs[7] = '{1'b0, 8'h00, 8'h77, 1, 0, -1, 1'b1, 5};
        vecs[8] = '{1'b1, 8'h96, 8'h00, 0, 4, 5, 1'b1, 6};
        vecs[9] = '{1'b0, 8'h00, 8'hC3, 0, 0, -1, 1'b1, 5};
        foreach (vecs[i]) begin
            idle(vecs[i].gap);
            run_cmd(vecs[i].wr, vecs[i].data, vecs[i].pin, vecs[i].hlo, vecs[i].hhi,
                    vecs[i].exp_turn, vecs[i].exp_len);
        end

        // Reset in the middle of a write's drive window.
        idle(1);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_data = 8'hE7;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        #1 chk("pre_rst_pad_o", 32'(pad_o), 32'hE7);
        chk("pre_rst_pad_t", 32'(pad_t), 32'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        #1 check_reset_vals("rst_mid_hold");
        rst_n = 1'b1;
        model_reset();
        idle(3);
        run_cmd(1'b1, 8'h42, 8'h00, 0, -1, 1'b1, 6);

        // Randomized commands against the transaction model.
        for (int n = 0; n < 60; n++) begin
            bit               wr, turn;
            logic [WIDTH-1:0] d, p;
            int               len, hlo, hhi;
            wr   = 1'($urandom);
            d    = WIDTH'($urandom);
            p    = WIDTH'($urandom);
            turn = (wr != m_last_dir);
            len  = (turn ? int'(TURN_CYC) : 0) + (wr ? int'(DRIVE_CYC) : int'(SAMPLE_CYC));
            hlo  = 0;
            hhi  = -1;
            if ($urandom_range(0, 2) == 0) begin
                hlo = int'($urandom_range(1, 7));
                hhi = hlo + int'($urandom_range(0, 2));
            end
            idle(int'($urandom_range(0, 2)));
            run_cmd(wr, d, p, hlo, hhi, turn, len);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iobuf_hdx_ctrl.md
IOBUF_HDX_CTRL -- requirements
Module: iobuf_hdx_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the pad bus and data width in bits.
REQ-002 Parameter TURN_CYC, default 2, range 1..255, SHALL set the bus turnaround length in cycles.
REQ-003 Parameter DRIVE_CYC, default 4, range 1..255, SHALL set the number of cycles a write drives the pad.
REQ-004 Parameter SAMPLE_CYC, default 3, range 1..255, SHALL set the number of released cycles before a read captures.
REQ-005 Port list SHALL be as follows; clock and reset come first.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  controller can accept a command.
- CMD_WR  in  1  1 = write, 0 = read; qualified by CMD_VALID.
- CMD_DATA  in  WIDTH  write data.
- RSP_VALID  out  1  one-cycle read-complete strobe.
- RSP_DATA  out  WIDTH  captured read data.
- HIZ  in  1  global high-Z override.
- PAD_I  in  WIDTH  pad receive data, from buffer O.
- PAD_O  out  WIDTH  pad drive data, to buffer I.
- PAD_T  out  WIDTH  tristate control per bit, to buffer T; 1 = released.
- BUSY  out  1  not in IDLE.

Function
REQ-006 FSM states SHALL be IDLE, TURN, DRIVE and SAMPLE.
REQ-007 CMD_READY SHALL equal (state==IDLE), combinationally; BUSY SHALL be its inverse.
REQ-008 A command SHALL be accepted on an edge where CMD_VALID and CMD_READY are both 1; CMD_WR and CMD_DATA SHALL be registered at acceptance.
REQ-009 Register last_dir SHALL record the direction of the most recently accepted command (1 = write).
REQ-010 On acceptance, if CMD_WR != last_dir, the next state SHALL be TURN; otherwise the next state SHALL be DRIVE for a write or SAMPLE for a read.
REQ-011 TURN SHALL last exactly TURN_CYC cycles with PAD_T all-ones, then go to DRIVE for a write or SAMPLE for a read.
REQ-012 DRIVE SHALL last exactly DRIVE_CYC cycles with PAD_T all-zeros and PAD_O equal to the registered CMD_DATA, then go to IDLE.
REQ-013 SAMPLE SHALL last exactly SAMPLE_CYC cycles with PAD_T all-ones.
REQ-014 On the edge ending the final SAMPLE cycle, PAD_I SHALL be captured into RSP_DATA, the FSM SHALL go to IDLE, and RSP_VALID SHALL be 1 for exactly the following cycle.
REQ-015 RSP_DATA SHALL hold its value until the next read capture; writes SHALL NOT produce RSP_VALID.
REQ-016 In IDLE, PAD_T SHALL be all-ones and PAD_O SHALL hold its last driven value.
REQ-017 HIZ=1 SHALL force PAD_T all-ones combinationally in every state.
- The FSM, its counters and last_dir SHALL continue unaffected.
- A write overlapped by HIZ still completes and still sets last_dir=1.
REQ-018 A command presented while BUSY SHALL NOT be accepted; CMD_VALID SHALL have no effect outside IDLE.
REQ-019 The cycle counter SHALL be 8 bits, SHALL load at each state entry and SHALL NOT wrap; no state SHALL last TURN_CYC/DRIVE_CYC/SAMPLE_CYC +/- 1 cycles.
REQ-020 Back-to-back commands SHALL be possible: IDLE lasts one cycle when CMD_VALID is held high.

Reset
REQ-021 While RST_N=0, regardless of clock, the outputs and state SHALL take these values:
- state=IDLE, last_dir=0 (read);
- PAD_T all-ones, PAD_O=0;
- RSP_VALID=0, RSP_DATA=0;
- CMD_READY=1, BUSY=0.
REQ-022 RST_N asserted mid-DRIVE or mid-SAMPLE SHALL abort the operation: pad released immediately, no RSP_VALID, in-flight command discarded.
REQ-023 Reset deassertion SHALL be synchronized internally, so that the first command is accepted no earlier than the second rising edge after RST_N rises.

Verification
REQ-024 Bench SHALL cover the following directed scenarios, using default parameters and cycle 0 = the accept edge.
- Write 0xA5 after reset -> TURN in cycles 1-2 (PAD_T=0xFF); PAD_T=0x00 and PAD_O=0xA5 in cycles 3-6; CMD_READY=1 in cycle 7.
- Write 0x3C then write 0x81 back-to-back -> second write accepted in cycle 7; no TURN; PAD_O=0x81 in cycles 8-11.
- Read following a write, PAD_I=0x5A -> TURN in cycles 8-9; SAMPLE in cycles 10-12; RSP_VALID=1 with RSP_DATA=0x5A in cycle 13 only.
- Read then read, PAD_I=0x11 then 0x22 -> no TURN on the second read; two RSP_VALID pulses 4 cycles apart with data 0x11 and 0x22.
- HIZ=1 during cycles 4-5 of a write -> PAD_T=0xFF in those cycles; write completes at cycle 7 and a following read inserts TURN.
- RST_N low in cycle 4 of a write -> PAD_T=0xFF and PAD_O=0x00 immediately; no response; after release the first write again inserts TURN.
